// File: rtl/nios2_oci_dct_packer.sv
// nios2_oci_dct_packer
//
// Debug compressed-trace (DCT) packer for the Nios II OCI trace path.
// It collects 2-bit trace atoms into a 30-bit buffer that holds up to 15 atoms.
// A completed frame moves into a one-frame holding register. The holding register
// is offered downstream through a valid/ready handshake.
//
// Parameters:
//   IDLE_TIMEOUT  number of cycles without an accepted atom before a partial buffer
//                 auto-flushes. 0 disables auto-flush.
//   TS_W          width of the frame timestamp. Used only with NIOS2_DCT_TIMESTAMP_EN.
//
// Optional feature (macro NIOS2_DCT_TIMESTAMP_EN):
//   Adds a free-running TS_W-bit cycle counter and the frame_ts_o output. frame_ts_o
//   holds the counter value from the cycle in which the frame was transferred.
//
// Ports:
//   clk_i          system clock
//   reset_i        asynchronous active-high reset
//   trace_en_i     atom capture enable
//   atom_valid_i   atom strobe
//   atom_i         atom code: 00 not-taken, 01 taken, 10 exception, 11 sync
//   flush_i        request to emit a partial buffer
//   ovf_clr_i      clears the sticky overflow flag
//   frame_ready_i  downstream accepts the held frame
//   frame_valid_o  holding register occupied
//   frame_data_o   packed atoms of the held frame
//   frame_count_o  atoms in the held frame (1..15)
//   frame_ts_o     transfer timestamp (optional)
//   dct_buffer_o   live collection buffer
//   dct_count_o    live atom count (0..15)
//   overflow_o     sticky: an atom was dropped
module nios2_oci_dct_packer #(
  parameter int unsigned IDLE_TIMEOUT = 64,
  parameter int unsigned TS_W         = 16
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            trace_en_i,
  input  logic            atom_valid_i,
  input  logic [1:0]      atom_i,
  input  logic            flush_i,
  input  logic            ovf_clr_i,
  input  logic            frame_ready_i,
  output logic            frame_valid_o,
  output logic [29:0]     frame_data_o,
  output logic [3:0]      frame_count_o,
`ifdef NIOS2_DCT_TIMESTAMP_EN
  output logic [TS_W-1:0] frame_ts_o,
`endif
  output logic [29:0]     dct_buffer_o,
  output logic [3:0]      dct_count_o,
  output logic            overflow_o
);

  localparam int unsigned IdleMax = (IDLE_TIMEOUT == 0) ? 0 : IDLE_TIMEOUT - 1;
  localparam int unsigned IdleW   = (IdleMax > 0) ? $clog2(IdleMax + 1) : 1;
  localparam logic [IdleW-1:0] IdleMaxW = IdleW'(IdleMax);

  typedef enum logic [1:0] {StCollect, StHold, StStall} state_e;

  state_e            state_q, state_d;
  logic [29:0]       buf_q, buf_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [29:0]       fdata_q, fdata_d;
  logic [3:0]        fcnt_q, fcnt_d;
  logic              pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic [IdleW-1:0]  idle_q, idle_d;

  logic        accept_try, is_sync, full, has_atoms, timeout;
  logic        req_base, sync_trig, hold_free, xfer, accepted, drop;
  logic [29:0] appended;

  always_comb begin
    accept_try = trace_en_i & atom_valid_i;
    is_sync    = (atom_i == 2'b11);
    full       = (cnt_q == 4'd15);
    has_atoms  = (cnt_q != 4'd0);
    timeout    = (IDLE_TIMEOUT != 0) && has_atoms && (idle_q == IdleMaxW);
    // pend_q holds a flush, timeout or sync request that arrived while the
    // holding register was busy.
    req_base   = full | (has_atoms & (flush_i | pend_q | timeout));
    // A sync atom with no other request is written first and then closes the frame.
    sync_trig  = accept_try & is_sync & ~req_base;
    hold_free  = (state_q == StCollect) | frame_ready_i;
    xfer       = (req_base | sync_trig) & hold_free;
    appended   = buf_q | ({28'b0, atom_i} << {cnt_q, 1'b0});

    buf_d    = buf_q;
    cnt_d    = cnt_q;
    fdata_d  = fdata_q;
    fcnt_d   = fcnt_q;
    pend_d   = pend_q;
    accepted = 1'b0;
    drop     = 1'b0;

    if (xfer) begin
      if (sync_trig) begin
        fdata_d  = appended;
        fcnt_d   = cnt_q + 4'd1;
        buf_d    = '0;
        cnt_d    = '0;
        pend_d   = 1'b0;
        accepted = 1'b1;
      end else begin
        // The incoming atom starts the freshly emptied buffer.
        fdata_d  = buf_q;
        fcnt_d   = cnt_q;
        buf_d    = accept_try ? {28'b0, atom_i} : '0;
        cnt_d    = accept_try ? 4'd1 : 4'd0;
        pend_d   = accept_try & is_sync;
        accepted = accept_try;
      end
    end else begin
      if (accept_try) begin
        if (full) begin
          drop = 1'b1;
        end else begin
          buf_d    = appended;
          cnt_d    = cnt_q + 4'd1;
          accepted = 1'b1;
          if (is_sync) pend_d = 1'b1;
        end
      end
      if (has_atoms & (flush_i | timeout)) pend_d = 1'b1;
    end

    ovf_d = drop | (ovf_q & ~ovf_clr_i);

    if (xfer | accepted) begin
      idle_d = '0;
    end else if (has_atoms && (idle_q != IdleMaxW)) begin
      idle_d = idle_q + 1'b1;
    end else begin
      idle_d = idle_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StCollect: if (xfer) state_d = StHold;
      StHold: begin
        if (frame_ready_i) begin
          state_d = xfer ? StHold : StCollect;
        end else if (req_base | sync_trig) begin
          state_d = StStall;
        end
      end
      StStall: if (frame_ready_i) state_d = xfer ? StHold : StCollect;
      default: state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StCollect;
      buf_q   <= '0;
      cnt_q   <= '0;
      fdata_q <= '0;
      fcnt_q  <= '0;
      pend_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      fdata_q <= fdata_d;
      fcnt_q  <= fcnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      idle_q  <= idle_d;
    end
  end

`ifdef NIOS2_DCT_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, fts_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ts_q  <= '0;
      fts_q <= '0;
    end else begin
      ts_q <= ts_q + 1'b1;
      if (xfer) fts_q <= ts_q;
    end
  end

  assign frame_ts_o = fts_q;
`else
  logic [TS_W-1:0] unused_ts;
  assign unused_ts = '0;
`endif

  assign frame_valid_o = (state_q != StCollect);
  assign frame_data_o  = fdata_q;
  assign frame_count_o = fcnt_q;
  assign dct_buffer_o  = buf_q;
  assign dct_count_o   = cnt_q;
  assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_nios2_oci_dct_packer.sv
// Self-checking bench for nios2_oci_dct_packer.
// The directed scenarios check against fixed expected constants.
// The randomized run checks against a queue-based model of the packing rules.
module tb_nios2_oci_dct_packer;
  localparam int unsigned IdleTo = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        trace_en, atom_valid, flush, ovf_clr, frame_ready;
  logic [1:0]  atom;
  logic        frame_valid, overflow;
  logic [29:0] frame_data, dct_buffer;
  logic [3:0]  frame_count, dct_count;
`ifdef NIOS2_DCT_TIMESTAMP_EN
  logic [15:0] frame_ts;
`endif

  int checks = 0;
  int failures = 0;

  nios2_oci_dct_packer #(.IDLE_TIMEOUT(IdleTo), .TS_W(16)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .trace_en_i   (trace_en),
    .atom_valid_i (atom_valid),
    .atom_i       (atom),
    .flush_i      (flush),
    .ovf_clr_i    (ovf_clr),
    .frame_ready_i(frame_ready),
    .frame_valid_o(frame_valid),
    .frame_data_o (frame_data),
    .frame_count_o(frame_count),
`ifdef NIOS2_DCT_TIMESTAMP_EN
    .frame_ts_o   (frame_ts),
`endif
    .dct_buffer_o (dct_buffer),
    .dct_count_o  (dct_count),
    .overflow_o   (overflow)
  );

  always #5 clk = ~clk;

  // Reference model state.
  int m_buf[$];
  int m_frm[$];
  bit m_fv, m_pend, m_ovf;
  int m_idle;

  function automatic logic [29:0] pack(input int q[$]);
    logic [29:0] v;
    v = '0;
    foreach (q[i]) v[2*i +: 2] = 2'(q[i]);
    return v;
  endfunction

  task automatic model_reset();
    m_buf.delete();
    m_frm.delete();
    m_fv = 0;
    m_pend = 0;
    m_ovf = 0;
    m_idle = 0;
  endtask

  // Advances the model by one clock, using the inputs currently driven.
  task automatic model_step();
    int n;
    bit acc, sync, tmo, want, strig, xf, took, drop;
    n     = m_buf.size();
    acc   = trace_en && atom_valid;
    sync  = (atom == 2'b11);
    tmo   = (IdleTo > 0) && (n > 0) && (m_idle + 1 >= IdleTo);
    want  = (n == 15) || ((n > 0) && (flush || m_pend || tmo));
    strig = acc && sync && !want;
    xf    = (want || strig) && (!m_fv || frame_ready);
    took  = 0;
    drop  = 0;
    if (m_fv && frame_ready) m_fv = 0;
    if (xf) begin
      m_frm = m_buf;
      if (strig) begin
        m_frm.push_back(3);
        took = 1;
      end
      m_buf.delete();
      m_fv = 1;
      m_pend = 0;
      if (acc && !strig) begin
        m_buf.push_back(int'(atom));
        took = 1;
        m_pend = sync;
      end
    end else begin
      if (acc) begin
        if (n == 15) drop = 1;
        else begin
          m_buf.push_back(int'(atom));
          took = 1;
          if (sync) m_pend = 1;
        end
      end
      if ((n > 0) && (flush || tmo)) m_pend = 1;
    end
    m_ovf = drop ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
    if (xf || took) m_idle = 0;
    else if (m_buf.size() > 0) m_idle++;
  endtask

  task automatic tick(input logic en, input logic av, input logic [1:0] a,
                      input logic fl, input logic clr, input logic rdy);
    trace_en = en;
    atom_valid = av;
    atom = a;
    flush = fl;
    ovf_clr = clr;
    frame_ready = rdy;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    trace_en = 0; atom_valid = 0; atom = 0; flush = 0; ovf_clr = 0; frame_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks += 6;
    if (frame_valid !== 1'b0) begin failures++; $display("FAIL reset_fv got=%b want=0", frame_valid); end
    if (frame_data !== 30'h0) begin failures++; $display("FAIL reset_fd got=%h want=0", frame_data); end
    if (frame_count !== 4'h0) begin failures++; $display("FAIL reset_fc got=%0d want=0", frame_count); end
    if (dct_buffer !== 30'h0) begin failures++; $display("FAIL reset_buf got=%h want=0", dct_buffer); end
    if (dct_count !== 4'h0) begin failures++; $display("FAIL reset_cnt got=%0d want=0", dct_count); end
    if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b want=0", overflow); end
  endtask

  task automatic test_full_frame();
    do_reset();
    for (int k = 1; k <= 15; k++) begin
      tick(1, 1, 2'b01, 0, 0, 0);
      checks++;
      if (dct_count !== 4'(k)) begin
        failures++; $display("FAIL full_cnt got=%0d want=%0d", dct_count, k);
      end
    end
    tick(1, 0, 2'b00, 0, 0, 0);
    checks += 4;
    if (frame_valid !== 1'b1) begin failures++; $display("FAIL full_fv got=%b want=1", frame_valid); end
    if (frame_data !== 30'h15555555) begin
      failures++; $display("FAIL full_fd got=%h want=15555555", frame_data);
    end
    if (frame_count !== 4'd15) begin failures++; $display("FAIL full_fc got=%0d want=15", frame_count); end
    if (dct_count !== 4'd0) begin failures++; $display("FAIL full_cnt0 got=%0d want=0", dct_count); end
    tick(1, 0, 2'b00, 0, 0, 1);
    checks++;
    if (frame_valid !== 1'b0) begin failures++; $display("FAIL full_acc got=%b want=0", frame_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    tick(1, 1, 2'b00, 0, 0, 0);
    tick(1, 1, 2'b01, 0, 0, 0);
    tick(1, 1, 2'b10, 0, 0, 0);
    tick(1, 0, 2'b00, 1, 0, 0);
    checks += 3;
    if (frame_valid !== 1'b1) begin failures++; $display("FAIL flush_fv got=%b want=1", frame_valid); end
    if (frame_data !== 30'h24) begin failures++; $display("FAIL flush_fd got=%h want=24", frame_data); end
    if (frame_count !== 4'd3) begin failures++; $display("FAIL flush_fc got=%0d want=3", frame_count); end
    tick(1, 0, 2'b00, 0, 0, 1);
    tick(1, 0, 2'b00, 1, 0, 1);
    tick(1, 0, 2'b00, 0, 0, 1);
    checks++;
    if (frame_valid !== 1'b0) begin failures++; $display("FAIL flush_empty got=%b want=0", frame_valid); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 1; k <= 31; k++) begin
      tick(1, 1, 2'b01, 0, 0, 0);
      if (k == 16) begin
        checks += 3;
        if (frame_valid !== 1'b1) begin failures++; $display("FAIL ovf_f1v got=%b want=1", frame_valid); end
        if (frame_count !== 4'd15) begin failures++; $display("FAIL ovf_f1c got=%0d want=15", frame_count); end
        if (dct_count !== 4'd1) begin failures++; $display("FAIL ovf_slot0 got=%0d want=1", dct_count); end
      end
      if (k == 30) begin
        checks += 2;
        if (dct_count !== 4'd15) begin failures++; $display("FAIL ovf_full got=%0d want=15", dct_count); end
        if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_early got=%b want=0", overflow); end
      end
    end
    checks += 2;
    if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b want=1", overflow); end
    if (dct_count !== 4'd15) begin failures++; $display("FAIL ovf_hold got=%0d want=15", dct_count); end
    tick(1, 0, 2'b00, 0, 0, 1);
    checks += 4;
    if (frame_valid !== 1'b1) begin failures++; $display("FAIL ovf_f2v got=%b want=1", frame_valid); end
    if (frame_count !== 4'd15) begin failures++; $display("FAIL ovf_f2c got=%0d want=15", frame_count); end
    if (frame_data !== 30'h15555555) begin
      failures++; $display("FAIL ovf_f2d got=%h want=15555555", frame_data);
    end
    if (dct_count !== 4'd0) begin failures++; $display("FAIL ovf_drain got=%0d want=0", dct_count); end
    tick(1, 0, 2'b00, 0, 0, 1);
    checks++;
    if (frame_valid !== 1'b0) begin failures++; $display("FAIL ovf_done got=%b want=0", frame_valid); end
    tick(1, 0, 2'b00, 0, 1, 1);
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clr got=%b want=0", overflow); end
  endtask

  task automatic test_idle_timeout();
    int seen;
    do_reset();
    tick(1, 1, 2'b10, 0, 0, 1);
    tick(1, 1, 2'b01, 0, 0, 1);
    seen = -1;
    for (int k = 1; k <= 100; k++) begin
      tick(1, 0, 2'b00, 0, 0, 1);
      if (seen < 0 && frame_valid === 1'b1) seen = k;
    end
    checks += 2;
    if (seen != int'(IdleTo)) begin failures++; $display("FAIL idle_delay got=%0d want=%0d", seen, IdleTo); end
    if (frame_count !== 4'd2) begin failures++; $display("FAIL idle_fc got=%0d want=2", frame_count); end
  endtask

  task automatic test_sync();
    do_reset();
    tick(1, 1, 2'b01, 0, 0, 0);
    tick(1, 1, 2'b11, 0, 0, 0);
    checks += 4;
    if (frame_valid !== 1'b1) begin failures++; $display("FAIL sync_fv got=%b want=1", frame_valid); end
    if (frame_data !== 30'hD) begin failures++; $display("FAIL sync_fd got=%h want=d", frame_data); end
    if (frame_count !== 4'd2) begin failures++; $display("FAIL sync_fc got=%0d want=2", frame_count); end
    if (dct_count !== 4'd0) begin failures++; $display("FAIL sync_cnt got=%0d want=0", dct_count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick(1, 1, 2'b01, 0, 0, 0);
    tick(1, 1, 2'b11, 0, 0, 0);
    for (int k = 0; k < 7; k++) tick(1, 1, 2'($urandom_range(0, 2)), 0, 0, 0);
    checks += 2;
    if (frame_valid !== 1'b1) begin failures++; $display("FAIL mid_pre_fv got=%b want=1", frame_valid); end
    if (dct_count !== 4'd7) begin failures++; $display("FAIL mid_pre_cnt got=%0d want=7", dct_count); end
    #2 reset = 1'b1;
    #1;
    checks += 4;
    if (frame_valid !== 1'b0) begin failures++; $display("FAIL mid_fv got=%b want=0", frame_valid); end
    if (frame_data !== 30'h0) begin failures++; $display("FAIL mid_fd got=%h want=0", frame_data); end
    if (dct_count !== 4'd0) begin failures++; $display("FAIL mid_cnt got=%0d want=0", dct_count); end
    if (dct_buffer !== 30'h0) begin failures++; $display("FAIL mid_buf got=%h want=0", dct_buffer); end
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    for (int k = 0; k < 5; k++) begin
      tick(1, 0, 2'b00, 0, 0, 1);
      checks++;
      if (frame_valid !== 1'b0) begin failures++; $display("FAIL mid_after got=%b want=0", frame_valid); end
    end
  endtask

  task automatic test_random();
    logic en, av, fl, clr, rdy;
    logic [1:0] a;
    int avp, rdp;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      case (c / 500)
        0: begin avp = 90; rdp = 50; end
        1: begin avp = 3;  rdp = 80; end
        2: begin avp = 95; rdp = 5;  end
        3: begin avp = 50; rdp = 90; end
        4: begin avp = 20; rdp = 30; end
        default: begin avp = 70; rdp = 60; end
      endcase
      en  = ($urandom_range(0, 99) < 95);
      av  = ($urandom_range(0, 99) < avp);
      a   = ($urandom_range(0, 99) < 6) ? 2'b11 : 2'($urandom_range(0, 2));
      fl  = ($urandom_range(0, 99) < 3);
      clr = ($urandom_range(0, 99) < 2);
      rdy = ($urandom_range(0, 99) < rdp);
      tick(en, av, a, fl, clr, rdy);
      checks += 6;
      if (dct_count !== 4'(m_buf.size())) begin
        failures++; $display("FAIL rnd_cnt c=%0d got=%0d want=%0d", c, dct_count, m_buf.size());
      end
      if (dct_buffer !== pack(m_buf)) begin
        failures++; $display("FAIL rnd_buf c=%0d got=%h want=%h", c, dct_buffer, pack(m_buf));
      end
      if (frame_valid !== m_fv) begin
        failures++; $display("FAIL rnd_fv c=%0d got=%b want=%b", c, frame_valid, m_fv);
      end
      if (frame_data !== pack(m_frm)) begin
        failures++; $display("FAIL rnd_fd c=%0d got=%h want=%h", c, frame_data, pack(m_frm));
      end
      if (frame_count !== 4'(m_frm.size())) begin
        failures++; $display("FAIL rnd_fc c=%0d got=%0d want=%0d", c, frame_count, m_frm.size());
      end
      if (overflow !== m_ovf) begin
        failures++; $display("FAIL rnd_ovf c=%0d got=%b want=%b", c, overflow, m_ovf);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_frame();
    test_flush();
    test_overflow();
    test_idle_timeout();
    test_sync();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nios2_oci_dct_packer.md
Name: nios2_oci_dct_packer

Overview:
- Debug compressed-trace (DCT) packer in the Nios II OCI trace path.
- Packs 2-bit branch/trace atoms from the CPU trace front-end into a 30-bit buffer of up to 15 atoms.
- Drives live dct_buffer/dct_count to the OCI simulation test-bench stage.
- Hands completed frames to the trace FIFO through a valid/ready handshake with a one-frame holding register.

Parameters:
- IDLE_TIMEOUT, 64: cycles without an accepted atom before a partial buffer auto-flushes; 0 disables auto-flush.
- TS_W, 16: timestamp width; used only when the optional feature is compiled in.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- trace_en  input  1  atom capture enable; atoms ignored when low.
- atom_valid  input  1  atom strobe.
- atom  input  2  00 not-taken, 01 taken, 10 exception, 11 sync.
- flush  input  1  single-cycle request to emit a partial buffer.
- ovf_clr  input  1  clears the overflow flag.
- frame_ready  input  1  downstream accepts the frame.
- frame_valid  output  1  holding register occupied.
- frame_data  output  30  packed atoms.
- frame_count  output  4  atoms in frame, 1..15.
- dct_buffer  output  30  live collection buffer.
- dct_count  output  4  live atom count, 0..15.
- overflow  output  1  sticky: an atom was dropped.

Behaviour:
- Reset: all outputs 0; idle counter 0. Reset takes effect immediately, including mid-frame; a pending frame is discarded.
- Atom acceptance: an atom is accepted when trace_en & atom_valid, unless buffer is full (count=15) and cannot transfer this cycle.
- Atom placement: atom k (0-based) is stored at dct_buffer[2k+1:2k]; dct_count increments by 1.
- Latency: dct_buffer/dct_count update 1 cycle after the atom.
- Sync atom (11) forces a transfer after it is written, as if the buffer were full.
- Transfer condition: count=15, or sync written, or (flush | idle timeout) with count>0.
- Transfer action: when the holding register is free (frame_valid=0, or frame_valid & frame_ready this cycle):
  - buffer → frame_data; count → frame_count.
  - frame_valid=1 the next cycle.
  - buffer and count clear to 0.
- Same-cycle atom and transfer:
  - If the transfer was triggered by full/flush/timeout, the incoming atom lands at slot 0 of the emptied buffer (count becomes 1).
  - If the transfer was triggered by a sync atom, the sync atom is included in the frame.
- Holding register busy: the transfer stalls and the buffer holds its contents.
  - At count=15, further atoms are dropped and overflow is set.
  - A flush arriving while stalled is latched (flush_pend) and serviced when the register frees.
- Handshake: frame_data/frame_count remain stable while frame_valid & !frame_ready. frame_valid deasserts the cycle after acceptance unless a new transfer loads in the same cycle (back-to-back frames).
- Idle timer: resets on each accepted atom or on a transfer; counts only while count>0; fires at IDLE_TIMEOUT.
- flush with count=0: no-op; no empty frame is ever emitted.
- overflow: set by a drop. ovf_clr clears it; a drop in the same cycle as ovf_clr wins (flag stays 1).
- FSM states:
  - COLLECT: holding register free.
  - HOLD: frame pending, buffer still collecting.
  - STALL: frame pending, transfer requested.
  - Transitions: COLLECT→HOLD on transfer; HOLD→COLLECT on accept with no request; HOLD→STALL on request; STALL→HOLD on accept (transfer executes).

Optional Feature:
- Macro: NIOS2_DCT_TIMESTAMP_EN.
- Defined: adds a free-running TS_W-bit cycle counter (wraps at 2^TS_W−1→0, reset 0) and output frame_ts [TS_W-1:0]. frame_ts captures the counter value of the cycle the transfer occurs and holds with frame_data.
- Undefined: no counter and no frame_ts port; identical timing otherwise.

Test Plan:
- Reset, then 15 atoms 01 back-to-back: dct_count 1..15, then frame_valid=1 with frame_data=0x15555555, frame_count=15; dct_count=0.
- 3 atoms (00,01,10) then flush: frame_data=0x00000024, frame_count=3; flush with count=0 → no frame.
- frame_ready=0, 31 atoms 01: first frame held, second buffer full at 15, one atom dropped, overflow=1; then raise frame_ready → two frames, count 15 each; ovf_clr → overflow=0.
- 2 atoms then idle with IDLE_TIMEOUT=64: frame emitted exactly 64 cycles after the last atom, frame_count=2.
- Atom 01 then sync 11: immediate frame, frame_data=0x0000000D, frame_count=2.
- Reset asserted mid-frame with frame_valid=1, count=7: all outputs 0 immediately; no frame after deassertion.
